// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI write controller.
// Optional request FIFO is enabled with SPI_CTRL_FIFO_EN.
package spi_pkg;

  localparam int SPI_FRAME_BITS = 16;
  localparam logic SPI_WR_BIT = 1'b1;
  localparam int SPI_ADDR_W = 7;
  localparam int SPI_DATA_W = 8;
  localparam int SPI_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

  typedef struct packed {
    logic [SPI_ADDR_W-1:0] addr;
    logic [SPI_DATA_W-1:0] wdata;
  } spi_req_t;

  function automatic logic [SPI_FRAME_BITS-1:0] spi_frame(
    input spi_req_t r
  );
    return {SPI_WR_BIT, r.addr, r.wdata};
  endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Four-entry request queue feeding the SPI shift engine.
// Only instantiated when SPI_CTRL_FIFO_EN is defined.
module spi_cmd_fifo
  import spi_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  logic     pop_i,
  input  spi_req_t wdata_i,
  output spi_req_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  spi_req_t   mem_q [SPI_FIFO_DEPTH];
  logic [1:0] wp_q;
  logic [1:0] rp_q;
  logic [2:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wp_q] <= wdata_i;
        wp_q        <= wp_q + 2'd1;
      end
      if (pop_i) begin
        rp_q <= rp_q + 2'd1;
      end
      cnt_q <= cnt_q + 3'(push_i) - 3'(pop_i);
    end
  end

  assign rdata_o = mem_q[rp_q];
  assign full_o  = cnt_q == 3'(SPI_FIFO_DEPTH);
  assign empty_o = cnt_q == 3'd0;

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 register-write master, 16-bit frames, MSB first.
// Define SPI_CTRL_FIFO_EN to queue up to four requests in front.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  m_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SPI_ADDR_W-1:0] addr,
  input  logic [SPI_DATA_W-1:0] wdata,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  s_clk,
  output logic                  data,
  output logic                  cs
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [4:0] LAST_BIT = 5'(SPI_FRAME_BITS);

  spi_state_e state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [4:0] bit_q, bit_d;
  logic [SPI_FRAME_BITS-1:0] sh_q, sh_d;
  logic cs_q, cs_d;
  logic sclk_q, sclk_d;
  logic done_q, done_d;

  logic div_last;
  logic gap_end;
  logic can_take;
  logic fifo_busy;
  logic idle_go;
  logic gap_go;
  spi_req_t req;

  assign div_last = div_q == DIV_LAST;
  assign gap_end  = (state_q == GAP) && div_last && bit_q[0];

`ifdef SPI_CTRL_FIFO_EN
  logic     accept;
  logic     f_push;
  logic     f_pop;
  logic     f_full;
  logic     f_empty;
  spi_req_t f_rdata;

  // A pop frees a slot this cycle, so a full queue still takes a push.
  assign f_pop     = gap_end && !f_empty;
  assign can_take  = !f_full || f_pop;
  assign fifo_busy = !f_empty;
  assign accept    = start && can_take;
  assign idle_go   = accept && (state_q == IDLE) && f_empty;
  assign f_push    = accept && !idle_go;
  assign gap_go    = f_pop;
  assign req       = f_pop ? f_rdata : {addr, wdata};

  spi_cmd_fifo u_fifo (
    .clk_i   (m_clk),
    .rst_i   (rst),
    .push_i  (f_push),
    .pop_i   (f_pop),
    .wdata_i ({addr, wdata}),
    .rdata_o (f_rdata),
    .full_o  (f_full),
    .empty_o (f_empty)
  );
`else
  assign can_take  = state_q == IDLE;
  assign fifo_busy = 1'b0;
  assign idle_go   = start && can_take;
  assign gap_go    = 1'b0;
  assign req       = {addr, wdata};
`endif

  always_ff @(posedge m_clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q + 8'd1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        div_d = '0;
        if (idle_go) begin
          state_d = SETUP;
          bit_d   = '0;
          sh_d    = spi_frame(req);
          cs_d    = 1'b0;
        end
      end
      SETUP: begin
        if (div_last) begin
          state_d = SHIFT;
          div_d   = '0;
          sclk_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (div_last) begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            sh_d   = sh_q << 1;
            bit_d  = bit_q + 5'd1;
          end else if (bit_q == LAST_BIT) begin
            state_d = HOLD;
          end else begin
            sclk_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (div_last) begin
          state_d = GAP;
          div_d   = '0;
          bit_d   = '0;
          cs_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        // bit_q splits the 2*CLK_DIV gap so div_q stays 8 bits wide
        if (div_last) begin
          div_d = '0;
          if (!bit_q[0]) begin
            bit_d = 5'd1;
          end else if (gap_go) begin
            state_d = SETUP;
            bit_d   = '0;
            sh_d    = spi_frame(req);
            cs_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ready = can_take;
    busy  = (state_q != IDLE) || fifo_busy;
    done  = done_q;
    s_clk = sclk_q;
    cs    = cs_q;
    data  = !cs_q && sh_q[SPI_FRAME_BITS-1];
  end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller with a behavioural SPI peripheral.
// FIFO scenario runs only when SPI_CTRL_FIFO_EN is defined.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       ready, busy, done, s_clk, data, cs;

  logic       start2 = 1'b0;
  logic [6:0] addr2 = '0;
  logic [7:0] wdata2 = '0;
  logic       ready2, busy2, done2, sclk2, data2, cs2;

  int n_chk = 0;
  int n_pass = 0;

  spi_controller #(.CLK_DIV(4)) u_dut (
    .m_clk (clk),
    .rst   (rst),
    .start (start),
    .addr  (addr),
    .wdata (wdata),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .s_clk (s_clk),
    .data  (data),
    .cs    (cs)
  );

  spi_controller #(.CLK_DIV(2)) u_dut2 (
    .m_clk (clk),
    .rst   (rst),
    .start (start2),
    .addr  (addr2),
    .wdata (wdata2),
    .ready (ready2),
    .busy  (busy2),
    .done  (done2),
    .s_clk (sclk2),
    .data  (data2),
    .cs    (cs2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  // Peripheral model for the CLK_DIV=4 instance
  logic        p_cs = 1'b1;
  logic        p_sclk = 1'b0;
  logic        p_data = 1'b0;
  logic [15:0] rx = '0;
  logic [15:0] last_frame = '0;
  int          nbits = 0;
  int          cs_low = 0;
  int          last_bits = 0;
  int          last_cs_low = 0;
  int          frames = 0;
  int          dones = 0;
  int          stab_err = 0;
  int          idle_err = 0;
  int          gap_run = 0;
  logic [7:0]  regs [5] = '{default: 8'h00};
  logic [15:0] fr_log [32] = '{default: 16'h0};
  int          gap_log [32] = '{default: 0};

  always @(negedge clk) begin
    if (!cs && p_cs) begin
      nbits  = 0;
      cs_low = 0;
      if (frames < 32) gap_log[frames] = gap_run;
    end
    if (!cs) cs_low++;
    if (cs) gap_run++;
    if (!cs && s_clk && !p_sclk) begin
      rx = {rx[14:0], data};
      nbits++;
    end
    if (s_clk && p_sclk && data !== p_data) stab_err++;
    if (cs && data) idle_err++;
    if (done) dones++;
    if (cs && !p_cs) begin
      last_frame  = rx;
      last_bits   = nbits;
      last_cs_low = cs_low;
      gap_run     = 1;
      if (frames < 32) fr_log[frames] = rx;
      frames++;
      if (nbits == 16 && rx[15] && rx[14:8] < 7'd5)
        regs[rx[10:8]] = rx[7:0];
    end
    p_cs   = cs;
    p_sclk = s_clk;
    p_data = data;
  end

  // Phase-length monitor for the CLK_DIV=2 instance
  logic        q_cs = 1'b1;
  logic        q_sclk = 1'b0;
  logic [15:0] rx2 = '0;
  logic [15:0] frame2 = '0;
  int          nb2 = 0;
  int          bits2 = 0;
  int          cl2 = 0;
  int          cs_low2 = 0;
  int          run2 = 0;
  int          frames2 = 0;
  int          hi_min = 255;
  int          hi_max = 0;
  int          lo_min = 255;
  int          lo_max = 0;

  always @(negedge clk) begin
    if (!cs2 && q_cs) begin
      nb2  = 0;
      cl2  = 0;
      run2 = 0;
    end
    if (!cs2) begin
      cl2++;
      if (!q_cs && sclk2 != q_sclk) begin
        if (q_sclk) begin
          if (run2 < hi_min) hi_min = run2;
          if (run2 > hi_max) hi_max = run2;
        end else begin
          if (run2 < lo_min) lo_min = run2;
          if (run2 > lo_max) lo_max = run2;
        end
        run2 = 0;
      end
      run2++;
      if (sclk2 && !q_sclk) begin
        rx2 = {rx2[14:0], data2};
        nb2++;
      end
    end
    if (cs2 && !q_cs) begin
      frame2  = rx2;
      bits2   = nb2;
      cs_low2 = cl2;
      frames2++;
    end
    q_cs   = cs2;
    q_sclk = sclk2;
  end

  task automatic wait_ready();
    int t = 0;
    while (!ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!ready) chk("ready_tmo", 32'(ready), 1);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    wait_ready();
    start = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int t = 0;
    while (frames < target && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("frame_tmo", 32'(frames >= target), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int f0, d0, t, g;
    logic [5:0] rdy;

    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs), 1);
    chk("rst_sclk", 32'(s_clk), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(ready), 1);
    rst = 1'b0;
    @(negedge clk);

    // Single write
    f0 = frames;
    d0 = dones;
    wr(7'h02, 8'hA5);
    chk("lat_cs", 32'(cs), 0);
    chk("lat_data", 32'(data), 1);
    chk("lat_busy", 32'(busy), 1);
`ifndef SPI_CTRL_FIFO_EN
    chk("lat_ready", 32'(ready), 0);
`endif
    t = 0;
    while (!done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 32'(done), 1);
`ifndef SPI_CTRL_FIFO_EN
    g = 0;
    while (!ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("gap_ready", 32'(g), 8);
`endif
    wait_frames(f0 + 1);
    chk("single_frame", 32'(last_frame), 32'h82A5);
    chk("single_bits", 32'(last_bits), 16);
    chk("single_cs_low", 32'(last_cs_low), 136);
    chk("single_dones", 32'(dones - d0), 1);
    chk("single_reg2", 32'(regs[2]), 32'hA5);

    // Loopback sweep plus out-of-range address
    f0 = frames;
    for (int i = 0; i < 5; i++) wr(7'(i), 8'((i + 1) * 17));
    wr(7'h05, 8'h66);
    wait_frames(f0 + 6);
    for (int i = 0; i < 5; i++)
      chk($sformatf("sweep_reg%0d", i), 32'(regs[i]), 32'((i + 1) * 17));
    chk("addr5_frame", 32'(last_frame), 32'h8566);

`ifndef SPI_CTRL_FIFO_EN
    // Second start while busy is dropped
    f0 = frames;
    wr(7'h01, 8'h77);
    repeat (9) @(negedge clk);
    chk("rej_ready", 32'(ready), 0);
    start = 1'b1;
    addr  = 7'h03;
    wdata = 8'h99;
    @(negedge clk);
    start = 1'b0;
    wait_frames(f0 + 1);
    repeat (100) @(negedge clk);
    chk("rej_frames", 32'(frames - f0), 1);
    chk("rej_reg1", 32'(regs[1]), 32'h77);
    chk("rej_reg3", 32'(regs[3]), 32'h44);
`endif

    // Reset in the middle of a frame
    d0 = dones;
    wr(7'h04, 8'hEE);
    @(negedge clk);
    t = 0;
    while (nbits != 7 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("mid_bit7", 32'(nbits), 7);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_cs", 32'(cs), 1);
    chk("mid_sclk", 32'(s_clk), 0);
    chk("mid_data", 32'(data), 0);
    chk("mid_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("mid_dones", 32'(dones - d0), 0);
    chk("mid_reg4", 32'(regs[4]), 32'h55);

    // Reset wins over a simultaneous start
    f0 = frames;
    rst   = 1'b1;
    start = 1'b1;
    addr  = 7'h00;
    wdata = 8'hCC;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("prio_cs", 32'(cs), 1);
    chk("prio_busy", 32'(busy), 0);
    repeat (20) @(negedge clk);
    chk("prio_frames", 32'(frames - f0), 0);

    // CLK_DIV=2 corner
    t = 0;
    while (!ready2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    start2 = 1'b1;
    addr2  = 7'h00;
    wdata2 = 8'hFF;
    @(negedge clk);
    start2 = 1'b0;
    t = 0;
    while (frames2 < 1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("div2_frame", 32'(frame2), 32'h80FF);
    chk("div2_bits", 32'(bits2), 16);
    chk("div2_cs_low", 32'(cs_low2), 68);
    chk("div2_hi_min", 32'(hi_min), 2);
    chk("div2_hi_max", 32'(hi_max), 2);
    chk("div2_lo_min", 32'(lo_min), 2);
    chk("div2_lo_max", 32'(lo_max), 2);

`ifdef SPI_CTRL_FIFO_EN
    // Six back-to-back starts into the queue
    f0 = frames;
    for (int i = 0; i < 6; i++) begin
      start  = 1'b1;
      addr   = 7'(i);
      wdata  = 8'(8'hA0 + i);
      rdy[i] = ready;
      @(negedge clk);
    end
    start = 1'b0;
    chk("fifo_ready", 32'(rdy), 32'h1F);
    wait_frames(f0 + 5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("fifo_frame%0d", k), 32'(fr_log[f0 + k]),
          32'({1'b1, 7'(k), 8'(8'hA0 + k)}));
    for (int k = 1; k < 5; k++)
      chk($sformatf("fifo_gap%0d", k), 32'(gap_log[f0 + k]), 8);
`endif

    chk("data_stable", 32'(stab_err), 0);
    chk("data_idle", 32'(idle_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 4, meaning the s_clk half-period in m_clk cycles (legal range 2..255).
REQ-002 SHALL provide port m_clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL provide port start, input, 1 bit: write-request strobe, accepted on any cycle where start && ready.
REQ-005 SHALL provide port addr, input, 7 bits: target register address, sampled on accept.
REQ-006 SHALL provide port wdata, input, 8 bits: write data, sampled on accept.
REQ-007 SHALL provide port ready, output, 1 bit: a request can be accepted this cycle.
REQ-008 SHALL provide port busy, output, 1 bit: a frame is in progress, or the CS-high gap is running.
REQ-009 SHALL provide port done, output, 1 bit: one-cycle pulse on the cycle cs returns high.
REQ-010 SHALL provide port s_clk, output, 1 bit: SPI clock, mode 0, idle low.
REQ-011 SHALL provide port data, output, 1 bit: serial out (MOSI), MSB first.
REQ-012 SHALL provide port cs, output, 1 bit: chip select, active low.

Function
REQ-013 Frame SHALL be 16 bits: {1'b1 (write), addr[6:0], wdata[7:0]}; addresses above 4 are sent unchanged.
REQ-014 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD and GAP; only IDLE accepts a request into the shift engine.
REQ-015 On accept in IDLE: the next cycle SHALL drive cs=0 and data=bit15, and enter SETUP.
REQ-016 SETUP SHALL last CLK_DIV cycles, then enter SHIFT.
REQ-017 SHIFT SHALL generate 16 s_clk periods, each with CLK_DIV cycles high followed by CLK_DIV cycles low.
REQ-018 In SHIFT, data SHALL change only on the cycle s_clk falls, and SHALL stay stable while s_clk is high.
REQ-019 After the 16th falling edge, the FSM SHALL enter HOLD with s_clk=0 for CLK_DIV cycles; cs then rises, done pulses and the FSM enters GAP.
REQ-020 cs SHALL be low for exactly 34*CLK_DIV cycles per frame.
REQ-021 GAP SHALL hold cs=1 for 2*CLK_DIV cycles before IDLE, guaranteeing the receiver sees a CS rise.
REQ-022 Without the FIFO, ready SHALL equal (state==IDLE), and start while not ready SHALL be ignored with no side effect.
REQ-023 The bit counter SHALL be 5 bits and the divider counter 8 bits; neither SHALL wrap within a frame.
REQ-024 data SHALL be 0 whenever cs=1.

Reset
REQ-025 On rst=1, the next cycle SHALL give cs=1, s_clk=0, data=0, done=0, busy=0 and state IDLE, with counters and FIFO cleared.
REQ-026 rst asserted mid-frame SHALL abort the frame with cs high immediately and no done pulse; the truncated frame is discarded by the receiver.
REQ-027 rst SHALL take priority over a simultaneous start.

Configuration
REQ-028 Macro SPI_CTRL_FIFO_EN, when defined, SHALL add a 4-entry request FIFO of {addr,wdata} in front of the shift engine.
REQ-029 With SPI_CTRL_FIFO_EN: ready SHALL be !full; a request accepted in IDLE with the FIFO empty SHALL bypass the FIFO with the same latency as REQ-015.
REQ-030 With SPI_CTRL_FIFO_EN: a queued request SHALL launch on the cycle after GAP ends, and busy SHALL stay high while the FIFO is non-empty.
REQ-031 With SPI_CTRL_FIFO_EN: a simultaneous pop and push with the FIFO full SHALL be accepted, and ready SHALL NOT drop.
REQ-032 Without SPI_CTRL_FIFO_EN, no FIFO storage SHALL be present and REQ-022 governs.

Structure
REQ-033 Shared package spi_pkg SHALL hold SPI_FRAME_BITS=16, SPI_WR_BIT=1'b1, SPI_ADDR_W=7, SPI_DATA_W=8 and the controller state enum.
REQ-034 The FIFO SHALL be sub-module spi_cmd_fifo, instantiated only under SPI_CTRL_FIFO_EN.

Verification
REQ-035 Single write: CLK_DIV=4, addr=0x02, wdata=0xA5 -> data sampled on 16 s_clk rises = 0x82A5, cs low for 136 cycles, done pulses once, and a paired spi_peripheral gives reg_2=0xA5.
REQ-036 Loopback sweep: write addr 0..4 with wdata 0x11,0x22,0x33,0x44,0x55 -> spi_peripheral reg_0..reg_4 match; a write to addr=0x05 changes no register.
REQ-037 Busy reject (no FIFO): a second start 10 cycles after the first -> ignored, exactly one frame, ready low until GAP ends.
REQ-038 Reset mid-frame: rst pulsed at bit 7 -> cs=1 and s_clk=0 next cycle, no done pulse, peripheral registers unchanged.
REQ-039 FIFO (SPI_CTRL_FIFO_EN): 6 consecutive-cycle starts -> first 5 accepted, ready low on the 6th, 5 frames sent in order, each separated by a CS-high gap of 8 cycles.
REQ-040 CLK_DIV=2 corner: a write of 0xFF to addr 0x00 -> each s_clk high and low phase lasts exactly 2 cycles, and the frame is correct.
